// File: rtl/main_mem_arbiter.sv
//------------------------------------------------------------------------------
// main_mem_arbiter
//   Shares the single-port main memory between the core's instruction-fetch
//   port (IF) and load/store port (DM). One transaction at a time: grant in
//   IDLE/RESP, one-cycle memory strobe in ISSUE, fixed-latency wait in WAIT,
//   one-cycle response pulse in RESP. DM has priority over IF.
//
//   Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN to let IF win
//   once STARVE_MAX consecutive DM grants have been issued while IF waited.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   if_req/if_addr            fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, data-valid pulse, fetched data
//   dm_req/dm_we/dm_be/
//   dm_addr/dm_wdata          load/store request, held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata load/store grant pulse, completion pulse, load data
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata        memory command, valid for one cycle on mem_en
//   mem_rdata                 memory read data, valid MEM_LAT cycles after mem_en
//   busy                      high whenever the arbiter is not IDLE
//------------------------------------------------------------------------------
module main_mem_arbiter #(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [XLEN/8-1:0] dm_be,
   input  logic [XLEN-1:0]   dm_addr,
   input  logic [XLEN-1:0]   dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [XLEN-1:0]   dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              busy
);

   localparam int unsigned CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     lat_cnt;
   logic              owner_dm;
   logic              we_q;
   logic [XLEN/8-1:0] be_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   if_rdata_q;
   logic [XLEN-1:0]   dm_rdata_q;
   logic              if_prio;
   logic              last_wait;

   assign last_wait = (state == WAIT) && (lat_cnt == CW'(1));

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] starve_cnt;

   // Counts DM grants that left IF waiting; any grant that does not starve IF clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (if_gnt) begin
         starve_cnt <= '0;
      end else if (dm_gnt) begin
         starve_cnt <= if_req ? starve_cnt + 3'd1 : '0;
      end
   end

   assign if_prio = (starve_cnt == 3'(STARVE_MAX));
`else
   assign if_prio = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // RESP doubles as IDLE so a new grant can overlap the response pulse.
   always_comb begin
      state_nxt = state;
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      if_rvalid = 1'b0;
      dm_rvalid = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         case (state)
            IDLE, RESP: begin
               if (state == RESP) begin
                  if_rvalid = !owner_dm;
                  dm_rvalid = owner_dm;
               end
               if (dm_req && !(if_req && if_prio)) begin
                  dm_gnt = 1'b1;
               end else if (if_req) begin
                  if_gnt = 1'b1;
               end
               state_nxt = (if_req || dm_req) ? ISSUE : IDLE;
            end
            ISSUE: begin
               mem_en    = 1'b1;
               mem_we    = we_q;
               mem_be    = be_q;
               mem_addr  = addr_q;
               mem_wdata = wdata_q;
               state_nxt = WAIT;
            end
            WAIT: begin
               if (lat_cnt == CW'(1)) begin
                  state_nxt = RESP;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cnt    <= '0;
         owner_dm   <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (if_gnt || dm_gnt) begin
            owner_dm <= dm_gnt;
            we_q     <= dm_gnt && dm_we;
            be_q     <= (dm_gnt && dm_we) ? dm_be : '1;
            addr_q   <= dm_gnt ? dm_addr : if_addr;
            wdata_q  <= (dm_gnt && dm_we) ? dm_wdata : '0;
         end
         if (state == ISSUE) begin
            lat_cnt <= CW'(MEM_LAT);
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - CW'(1);
         end
         if (last_wait) begin
            if (owner_dm) begin
               dm_rdata_q <= we_q ? '0 : mem_rdata;
            end else begin
               if_rdata_q <= mem_rdata;
            end
         end
      end
   end

   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_main_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_main_mem_arbiter
//   Self-checking bench for main_mem_arbiter (XLEN=64, MEM_LAT=2, STARVE_MAX=4).
//   Memory model returns rdata = address, MEM_LAT cycles after mem_en, and
//   random garbage in every other cycle. Inputs change on the falling edge;
//   outputs are checked 1 ns later.
//------------------------------------------------------------------------------
module tb_main_mem_arbiter;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned MEM_LAT    = 2;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned OUT_W      = 7 + 4 * XLEN + XLEN / 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [XLEN-1:0]   if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [XLEN-1:0]   if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [XLEN/8-1:0] dm_be;
   logic [XLEN-1:0]   dm_addr;
   logic [XLEN-1:0]   dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [XLEN-1:0]   dm_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [XLEN/8-1:0] mem_be;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN-1:0]   mem_rdata;
   logic              busy;
   logic [OUT_W-1:0]  all_out;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   main_mem_arbiter #(
      .XLEN       (XLEN),
      .MEM_LAT    (MEM_LAT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   assign all_out = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                     mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: fixed latency, rdata = address, garbage when not due.
   typedef struct {
      int unsigned     due;
      logic [XLEN-1:0] data;
   } rsp_t;
   rsp_t        mq[$];
   int unsigned mcyc = 0;

   always begin
      @(negedge clk);
      mcyc++;
      #1;
      mem_rdata = {$urandom, $urandom};
      if (mq.size() != 0 && mq[0].due == mcyc) begin
         mem_rdata = mq[0].data;
         void'(mq.pop_front());
      end
      if (mem_en) begin
         mq.push_back('{due: mcyc + MEM_LAT, data: mem_addr});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, simulation stopped");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_be    = '0;
      dm_addr  = '0;
      dm_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++;
         $display("FAIL post_reset_idle: got %h expected 0", all_out);
      end
      // fetch to 0x40, then reset while it is in WAIT
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 64'h40;
      #1;
      n_cmp++;
      if (if_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL reset_fetch_gnt: got %b expected 1", if_gnt);
      end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      n_cmp++;
      if ({mem_en, mem_addr} !== {1'b1, 64'h40}) begin
         n_err++;
         $display("FAIL reset_fetch_issue: got en=%b addr=%h expected en=1 addr=40", mem_en, mem_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int unsigned c = 0; c < 5; c++) begin
         if (c != 0) @(negedge clk);
         #1;
         n_cmp++;
         if (all_out !== '0) begin
            n_err++;
            $display("FAIL abort_idle[%0d]: got %h expected 0", c, all_out);
         end
      end
   endtask

   task automatic test_fetch();
      do_reset();
      for (int unsigned c = 0; c < 6; c++) begin
         @(negedge clk);
         if_req  = (c == 0);
         if_addr = 64'h40;
         #1;
         n_cmp++;
         if ({if_gnt, dm_gnt, mem_en, if_rvalid, busy} !==
             {c == 0, 1'b0, c == 1, c == 4, c >= 1 && c <= 4}) begin
            n_err++;
            $display("FAIL fetch_ctrl[%0d]: got gnt=%b en=%b rvalid=%b busy=%b", c, if_gnt, mem_en, if_rvalid, busy);
         end
         if (c == 1) begin
            n_cmp++;
            if ({mem_we, mem_be, mem_addr} !== {1'b0, 8'hFF, 64'h40}) begin
               n_err++;
               $display("FAIL fetch_issue: got we=%b be=%h addr=%h expected we=0 be=ff addr=40", mem_we, mem_be, mem_addr);
            end
         end
         if (c >= 4) begin
            n_cmp++;
            if (if_rdata !== 64'h40) begin
               n_err++;
               $display("FAIL fetch_rdata[%0d]: got %h expected 40", c, if_rdata);
            end
         end
      end
   endtask

   task automatic test_store();
      do_reset();
      for (int unsigned c = 0; c < 6; c++) begin
         @(negedge clk);
         dm_req   = (c == 0);
         dm_we    = 1'b1;
         dm_be    = 8'h0F;
         dm_addr  = 64'h100;
         dm_wdata = 64'hDEAD_BEEF;
         #1;
         n_cmp++;
         if ({dm_gnt, if_gnt, mem_en, dm_rvalid} !== {c == 0, 1'b0, c == 1, c == 4}) begin
            n_err++;
            $display("FAIL store_ctrl[%0d]: got gnt=%b en=%b rvalid=%b", c, dm_gnt, mem_en, dm_rvalid);
         end
         if (c == 1) begin
            n_cmp++;
            if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 8'h0F, 64'h100, 64'hDEAD_BEEF}) begin
               n_err++;
               $display("FAIL store_issue: got we=%b be=%h addr=%h wdata=%h", mem_we, mem_be, mem_addr, mem_wdata);
            end
         end
         if (c == 4) begin
            n_cmp++;
            if (dm_rdata !== '0) begin
               n_err++;
               $display("FAIL store_rdata: got %h expected 0", dm_rdata);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int unsigned c = 0; c < 10; c++) begin
         @(negedge clk);
         if_req  = (c <= 4);
         if_addr = 64'h40;
         dm_req  = (c == 0);
         dm_we   = 1'b0;
         dm_addr = 64'h200;
         #1;
         n_cmp++;
         if ({if_gnt, dm_gnt} !== {c == 4, c == 0}) begin
            n_err++;
            $display("FAIL simul_gnt[%0d]: got if=%b dm=%b expected if=%b dm=%b", c, if_gnt, dm_gnt, c == 4, c == 0);
         end
         n_cmp++;
         if ({dm_rvalid, if_rvalid} !== {c == 4, c == 8}) begin
            n_err++;
            $display("FAIL simul_rvalid[%0d]: got dm=%b if=%b", c, dm_rvalid, if_rvalid);
         end
         if (c == 4) begin
            n_cmp++;
            if (dm_rdata !== 64'h200) begin
               n_err++;
               $display("FAIL simul_dm_rdata: got %h expected 200", dm_rdata);
            end
         end
         if (c == 8) begin
            n_cmp++;
            if ({if_rdata, dm_rdata} !== {64'h40, 64'h200}) begin
               n_err++;
               $display("FAIL simul_if_rdata: got if=%h dm=%h expected if=40 dm=200", if_rdata, dm_rdata);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic prev_en = 1'b0;
      do_reset();
      for (int unsigned c = 0; c < 14; c++) begin
         @(negedge clk);
         dm_req  = (c <= 8);
         dm_we   = 1'b0;
         dm_addr = 64'(8 * (c / 4));
         #1;
         n_cmp++;
         if ({dm_gnt, mem_en, dm_rvalid} !==
             {c % 4 == 0 && c <= 8, c % 4 == 1 && c <= 9, c % 4 == 0 && c >= 4 && c <= 12}) begin
            n_err++;
            $display("FAIL b2b_ctrl[%0d]: got gnt=%b en=%b rvalid=%b", c, dm_gnt, mem_en, dm_rvalid);
         end
         n_cmp++;
         if (prev_en && mem_en) begin
            n_err++;
            $display("FAIL b2b_mem_en_consecutive[%0d]: got 1 expected 0", c);
         end
         prev_en = mem_en;
         if (dm_rvalid) begin
            n_cmp++;
            if (dm_rdata !== 64'(8 * (c / 4 - 1))) begin
               n_err++;
               $display("FAIL b2b_rdata[%0d]: got %h expected %h", c, dm_rdata, 64'(8 * (c / 4 - 1)));
            end
         end
      end
   endtask

   task automatic test_starvation();
      int unsigned streak = 0;
      logic        exp_if;
      logic        exp_dm;
      do_reset();
      for (int unsigned c = 0; c < 40; c++) begin
         @(negedge clk);
         if_req  = 1'b1;
         if_addr = 64'h40;
         dm_req  = 1'b1;
         dm_we   = 1'b0;
         dm_addr = 64'h300;
         #1;
         exp_if = 1'b0;
         exp_dm = 1'b0;
         if (c % (MEM_LAT + 2) == 0) begin
            if (GUARD && streak == STARVE_MAX) begin
               exp_if = 1'b1;
               streak = 0;
            end else begin
               exp_dm = 1'b1;
               streak++;
            end
         end
         n_cmp++;
         if ({if_gnt, dm_gnt} !== {exp_if, exp_dm}) begin
            n_err++;
            $display("FAIL starve_gnt[%0d]: got if=%b dm=%b expected if=%b dm=%b", c, if_gnt, dm_gnt, exp_if, exp_dm);
         end
      end
      clear_inputs();
   endtask

   task automatic test_random();
      logic              ip = 1'b0;
      logic              dp = 1'b0;
      int                next_free = 0;
      int                g_last = -100;
      int unsigned       streak = 0;
      logic              t_dm = 1'b0;
      logic              t_we = 1'b0;
      logic [XLEN/8-1:0] t_be = '0;
      logic [XLEN-1:0]   t_addr = '0;
      logic [XLEN-1:0]   t_wdata = '0;
      logic [XLEN-1:0]   h_if = '0;
      logic [XLEN-1:0]   h_dm = '0;
      logic              e_ig, e_dg, e_en, e_irv, e_drv, e_busy;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!ip && $urandom_range(2) == 0) begin
            ip      = 1'b1;
            if_addr = {$urandom, $urandom};
         end
         if (!dp && $urandom_range(2) == 0) begin
            dp       = 1'b1;
            dm_we    = 1'($urandom_range(1));
            dm_be    = 8'($urandom);
            dm_addr  = {$urandom, $urandom};
            dm_wdata = {$urandom, $urandom};
         end
         if_req = ip;
         dm_req = dp;
         #1;
         // transaction granted at g_last: issue one cycle later, respond MEM_LAT+2 later
         e_en   = (c == g_last + 1);
         e_irv  = (c == g_last + int'(MEM_LAT) + 2) && !t_dm;
         e_drv  = (c == g_last + int'(MEM_LAT) + 2) && t_dm;
         e_busy = (c > g_last) && (c <= g_last + int'(MEM_LAT) + 2);
         if (e_irv) h_if = t_addr;
         if (e_drv) h_dm = t_we ? '0 : t_addr;
         e_ig = 1'b0;
         e_dg = 1'b0;
         if (c >= next_free && (ip || dp)) begin
            if (dp && !(GUARD && ip && streak == STARVE_MAX)) e_dg = 1'b1;
            else e_ig = 1'b1;
         end
         n_cmp++;
         if ({if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid, busy} !== {e_ig, e_dg, e_en, e_irv, e_drv, e_busy}) begin
            n_err++;
            $display("FAIL rand_ctrl[%0d]: got ig/dg/en/irv/drv/busy=%b expected %b", c,
                     {if_gnt, dm_gnt, mem_en, if_rvalid, dm_rvalid, busy}, {e_ig, e_dg, e_en, e_irv, e_drv, e_busy});
         end
         n_cmp++;
         if ({if_rdata, dm_rdata} !== {h_if, h_dm}) begin
            n_err++;
            $display("FAIL rand_rdata[%0d]: got if=%h dm=%h expected if=%h dm=%h", c, if_rdata, dm_rdata, h_if, h_dm);
         end
         if (e_en) begin
            n_cmp++;
            if ({mem_we, mem_be, mem_addr} !== {t_we, t_be, t_addr} || (t_we && mem_wdata !== t_wdata)) begin
               n_err++;
               $display("FAIL rand_issue[%0d]: got we=%b be=%h addr=%h wdata=%h expected we=%b be=%h addr=%h wdata=%h", c,
                        mem_we, mem_be, mem_addr, mem_wdata, t_we, t_be, t_addr, t_wdata);
            end
         end
         if (e_ig || e_dg) begin
            g_last    = c;
            next_free = c + int'(MEM_LAT) + 2;
            t_dm      = e_dg;
            t_we      = e_dg && dm_we;
            t_be      = (e_dg && dm_we) ? dm_be : '1;
            t_addr    = e_dg ? dm_addr : if_addr;
            t_wdata   = dm_wdata;
            if (e_ig) begin
               streak = 0;
               ip     = 1'b0;
            end else begin
               streak = ip ? streak + 1 : 0;
               dp     = 1'b0;
            end
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      rst       = 1'b1;
      mem_rdata = '0;
      clear_inputs();
      test_reset();
      test_fetch();
      test_store();
      test_simultaneous();
      test_back_to_back();
      test_starvation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/main_mem_arbiter.md
Name: main_mem_arbiter

Overview:
- Shares the single-port main memory (instruction + data image) between two requesters: the core's instruction-fetch port (IF) and its load/store port (DM).
- Sits between the core pipeline and the main memory.
- Grants one transaction at a time, sequences the fixed-latency memory access and returns the read data or write acknowledge to the winning requester.
- DM has priority over IF. An optional starvation guard bounds how long IF can be blocked.

Parameters:
- XLEN, 64, data and address width.
- MEM_LAT, 2, main-memory read latency in cycles from the mem_en cycle to mem_rdata valid; must be ≥1.
- STARVE_MAX, 4, maximum consecutive DM grants while IF is pending (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  XLEN  fetch byte address.
- if_gnt  out  1  one-cycle pulse; request captured.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  XLEN  fetched doubleword.
- dm_req  in  1  load/store request; held until dm_gnt.
- dm_we  in  1  1=store, 0=load.
- dm_be  in  XLEN/8  store byte enables.
- dm_addr  in  XLEN  data byte address.
- dm_wdata  in  XLEN  store data.
- dm_gnt  out  1  one-cycle pulse; request captured.
- dm_rvalid  out  1  one-cycle pulse; load data valid or store complete.
- dm_rdata  out  XLEN  load data; 0 for stores.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_be  out  XLEN/8  memory byte enables; all ones for reads.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset: all outputs 0 except mem_be=0; state=IDLE; latency counter=0; starvation counter=0.
- Reset is synchronous and asserted mid-transaction:
  - aborts the transaction; no rvalid is produced for it;
  - any mem_rdata that arrives afterwards is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, in the cycle T where any req is high:
  - select the winner;
  - assert its gnt combinationally in cycle T;
  - register owner, addr, we, be, wdata;
  - go to ISSUE.
- Arbitration without the guard: dm_req wins over if_req.
- Simultaneous requests: exactly one gnt; the loser keeps its req asserted.
- ISSUE (cycle T+1):
  - mem_en=1;
  - drive the registered addr, we, be (all ones for reads and fetches), wdata;
  - load the latency counter with MEM_LAT;
  - go to WAIT.
- WAIT:
  - decrement the counter each cycle;
  - at cycle T+1+MEM_LAT, sample mem_rdata into the owner's rdata register (stores load 0);
  - go to RESP.
- RESP (cycle T+2+MEM_LAT):
  - owner's rvalid=1 for exactly one cycle;
  - rdata holds its value until the next response to that owner;
  - the same cycle behaves as IDLE, so a new gnt may coincide with rvalid.
- Throughput: one transaction per MEM_LAT+2 cycles when requests are back-to-back.
- gnt is never asserted outside IDLE/RESP.
- if_gnt and dm_gnt are never high together.
- Requests arriving during ISSUE or WAIT are held off; no gnt is given.
- mem_en is never high in consecutive cycles.
- Addresses pass through unmodified; no alignment checking.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - a 3-bit counter increments on each dm_gnt issued while if_req is high;
  - it clears on if_gnt, or on a dm_gnt issued with if_req low;
  - when the counter equals STARVE_MAX and both requests are high, IF wins and the counter clears.
- Undefined: strict DM priority; the counter logic is absent.

Test Plan (memory model returns rdata = address, MEM_LAT=2):
- Reset mid-WAIT of an IF fetch to 0x40, then idle → no if_rvalid; all outputs 0; busy=0 from the cycle after reset.
- Single IF fetch to 0x40 in cycle 0 → if_gnt at cycle 0; mem_en=1, mem_addr=0x40, mem_we=0 at cycle 1; if_rvalid=1, if_rdata=0x40 at cycle 4.
- DM store to addr 0x100 with wdata 0xDEAD_BEEF and be=0x0F → mem_en/mem_we=1 with those values at cycle 1; dm_rvalid=1, dm_rdata=0 at cycle 4.
- if_req and dm_req (load 0x200) both asserted at cycle 0 → dm_gnt at cycle 0, dm_rdata=0x200 at cycle 4; if_gnt at cycle 4, if_rdata=0x40 at cycle 8.
- Back-to-back DM loads at addresses 0x0, 0x8, 0x10 → grants at cycles 0, 4, 8; mem_en never high in two consecutive cycles.
- With MEM_ARB_STARVE_GUARD_EN, dm_req and if_req held high continuously → 4 dm_gnt, then if_gnt on the 5th grant (cycle 16); without the macro → IF never granted within 40 cycles.
